// File: rtl/hitfx_pkg.sv
// Shared types, constants and palette for the hit-effect sprite source.
package hitfx_pkg;

  typedef enum logic [1:0] {
    MANUAL  = 2'b00,
    LOOP    = 2'b01,
    ONESHOT = 2'b10,
    OFF     = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Scan column that marks the start of a video frame (with y==0).
  localparam int TICK_X = 1;

  // Native width of the palette table entries.
  localparam int PAL_CD = 12;

  // Palette code to colour; code 0 is the transparent key.
  function automatic logic [PAL_CD-1:0] pal_lookup(input logic [3:0] code,
                                                   input logic [PAL_CD-1:0] key);
    case (code)
      4'h0:    pal_lookup = key;
      4'h2:    pal_lookup = 12'hf00;
      4'h9:    pal_lookup = 12'h0f0;
      4'hA:    pal_lookup = 12'h0ff;
      4'hC:    pal_lookup = 12'h630;
      4'hD:    pal_lookup = 12'h500;
      default: pal_lookup = 12'hfff;
    endcase
  endfunction

endpackage

// File: rtl/hitfx_sprite_ram.sv
// Simple dual-port sprite RAM: one write port, one registered read port.
module hitfx_sprite_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] data_r
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write and read share the edge; a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= data_w;
    data_r <= mem[addr_r];
  end

endmodule

// File: rtl/hitfx_sprite_src.sv
// Animated hit-effect sprite source with manual, looping and one-shot modes.
import hitfx_pkg::*;

module hitfx_sprite_src #(
  parameter int            CD        = 12,
  parameter int            H_SIZE    = 16,
  parameter int            V_SIZE    = 16,
  parameter int            N_FRAMES  = 4,
  parameter int            FRAME_DIV = 10,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  parameter int            ADDR      = $clog2(N_FRAMES) + $clog2(V_SIZE) + $clog2(H_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [10:0]                 x,
  input  logic [10:0]                 y,
  input  logic [10:0]                 x0,
  input  logic [10:0]                 y0,
  input  logic [1:0]                  mode,
  input  logic [$clog2(N_FRAMES)-1:0] frame_sel,
  input  logic                        trigger,
  input  logic                        we,
  input  logic [ADDR-1:0]             addr_w,
  input  logic [3:0]                  pixel_in,
  output logic                        busy,
  output logic                        done,
  output logic [CD-1:0]               sprite_rgb
);

  localparam int FW = $clog2(N_FRAMES);
  localparam int HW = $clog2(H_SIZE);
  localparam int VW = $clog2(V_SIZE);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  mode_t          m;
  state_t         state;
  logic [10:0]    x_d1;
  logic [DW-1:0]  div;
  logic [FW-1:0]  frame;
  logic [10:0]    ox, oy;
  logic           frame_tick, adv;

  logic [10:0]    org_x, org_y;
  logic [11:0]    xr, yr;
  logic           in_region, visible;
  logic [FW-1:0]  fidx;
  logic [ADDR-1:0] addr_r;
  logic [3:0]     rd;
  logic           hit1;

  assign m          = mode_t'(mode);
  assign frame_tick = (x_d1 == '0) && (x == 11'(TICK_X)) && (y == '0);
  assign adv        = frame_tick && (div == DW'(FRAME_DIV - 1));

  // Delayed scan column for frame-start detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) x_d1 <= '0;
    else       x_d1 <= x;
  end

  // Animation divider/frame counter and one-shot sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div   <= '0;
      frame <= '0;
      ox    <= '0;
      oy    <= '0;
    end else begin
      done <= 1'b0;
      if (frame_tick) div <= (div == DW'(FRAME_DIV - 1)) ? '0 : div + 1'b1;
      if (m != ONESHOT) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (adv) frame <= frame + 1'b1;
      end else if (trigger) begin
        // Trigger overrides a coincident advance, including the final one.
        state <= PLAY;
        busy  <= 1'b1;
        ox    <= x0;
        oy    <= y0;
        frame <= '0;
        div   <= '0;
      end else if (state == PLAY && adv) begin
        if (frame == FW'(N_FRAMES - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          frame <= frame + 1'b1;
        end
      end
    end
  end

  // Region test in signed scan space so negative offsets never alias.
  always_comb begin
    org_x     = (m == ONESHOT) ? ox : x0;
    org_y     = (m == ONESHOT) ? oy : y0;
    xr        = {1'b0, x} - {1'b0, org_x};
    yr        = {1'b0, y} - {1'b0, org_y};
    in_region = !xr[11] && (xr < 12'(H_SIZE)) && !yr[11] && (yr < 12'(V_SIZE));
    fidx      = (m == MANUAL) ? frame_sel : frame;
    visible   = (m == MANUAL) || (m == LOOP) || (m == ONESHOT && state == PLAY);
    addr_r    = {fidx, yr[VW-1:0], xr[HW-1:0]};
  end

  hitfx_sprite_ram #(
    .ADDR_WIDTH(ADDR),
    .DATA_WIDTH(4)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .addr_w (addr_w),
    .data_w (pixel_in),
    .addr_r (addr_r),
    .data_r (rd)
  );

  // Stage 1 visibility flag alongside the RAM read; stage 2 palette and key mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1       <= 1'b0;
      sprite_rgb <= KEY_COLOR;
    end else begin
      hit1       <= visible && in_region;
      sprite_rgb <= hit1 ? CD'(pal_lookup(rd, 12'(KEY_COLOR))) : KEY_COLOR;
    end
  end

endmodule

// File: tb/tb_hitfx_sprite_src.sv
// Scoreboard bench for hitfx_sprite_src (FRAME_DIV=2, 4 frames, 16x16).
module tb_hitfx_sprite_src;

  localparam int CD = 12;
  localparam logic [CD-1:0] KEY = 12'h000;
  localparam logic [CD-1:0] MARK [4] = '{12'hf00, 12'h0f0, 12'h0ff, 12'h630};

  typedef struct {
    int            px;
    int            py;
    logic [CD-1:0] c;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   x = 11'd500, y = 11'd500, x0 = '0, y0 = '0;
  logic [1:0]    mode = 2'b11;
  logic [1:0]    frame_sel = '0;
  logic          trigger = 1'b0, we = 1'b0;
  logic [9:0]    addr_w = '0;
  logic [3:0]    pixel_in = '0;
  logic          busy, done;
  logic [CD-1:0] sprite_rgb;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic probe = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic seen_done;

  hitfx_sprite_src #(
    .CD(12), .H_SIZE(16), .V_SIZE(16), .N_FRAMES(4), .FRAME_DIV(2), .KEY_COLOR(12'h000)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .x0(x0), .y0(y0), .mode(mode),
    .frame_sel(frame_sel), .trigger(trigger), .we(we), .addr_w(addr_w),
    .pixel_in(pixel_in), .busy(busy), .done(done), .sprite_rgb(sprite_rgb)
  );

  always #5 clk = ~clk;

  // Probe flag follows the 2-clock pixel latency.
  always @(posedge clk) begin
    p1 <= probe;
    p2 <= p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected pixels when a probed pixel reaches the output.
  always @(negedge clk) begin
    if (p2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: got pixel %0h expected none", sprite_rgb);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("pixel(%0d,%0d)", e.px, e.py), 32'(sprite_rgb), 32'(e.c));
      end
    end
  end

  task automatic wr(input int a, input logic [3:0] c);
    @(negedge clk); we = 1'b1; addr_w = 10'(a); pixel_in = c;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic probe_px(input int px, input int py, input logic [CD-1:0] c);
    exp_t e;
    @(negedge clk); x = 11'(px); y = 11'(py); probe = 1'b1;
    e.px = px; e.py = py; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic park();
    @(negedge clk); x = 11'd500; y = 11'd500; probe = 1'b0;
  endtask

  // One video frame: probe a pixel, then x=0 -> x=1 on y=0 to raise frame_tick.
  task automatic vframe(input int px, input int py, input logic [CD-1:0] c, input logic trig);
    probe_px(px, py, c);
    @(negedge clk); x = 11'd0; y = 11'd0; probe = 1'b0;
    @(negedge clk); x = 11'd1; y = 11'd0; trigger = trig;
    @(negedge clk); x = 11'd500; y = 11'd500; trigger = 1'b0;
  endtask

  task automatic pulse_trig();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(sprite_rgb), 32'(KEY));
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b0;

    // Clear RAM, then place frame markers and test pixels.
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk); we = 1'b1; addr_w = 10'(a); pixel_in = 4'h0;
    end
    @(negedge clk); we = 1'b0;
    wr(0, 4'h2); wr(256, 4'h9); wr(512, 4'hA); wr(768, 4'hC);
    wr(309, 4'h2); wr(7, 4'h9); wr(15, 4'hD);

    // MANUAL, frame 1, origin (10,10)
    mode = 2'b00; frame_sel = 2'd1; x0 = 11'd10; y0 = 11'd10;
    probe_px(15, 13, 12'hf00);
    probe_px(10, 10, 12'h0f0);
    probe_px(9, 13, KEY);
    probe_px(26, 13, KEY);
    probe_px(25, 13, KEY);
    park();

    // Edges: origin (0,0) and (2040,0)
    frame_sel = 2'd0; x0 = 11'd0; y0 = 11'd0;
    probe_px(2047, 0, KEY);
    probe_px(0, 0, 12'hf00);
    probe_px(15, 0, 12'h500);
    probe_px(0, 16, KEY);
    park();
    x0 = 11'd2040;
    probe_px(2047, 0, 12'h0f0);
    probe_px(7, 0, KEY);
    probe_px(2039, 0, KEY);
    park();

    // LOOP: ten video frames from a clean counter
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; mode = 2'b01; x0 = 11'd0; y0 = 11'd0;
    for (int k = 0; k < 10; k++) vframe(0, 0, MARK[(k / 2) % 4], 1'b0);

    // ONESHOT: latch (100,50), move live origin away
    park();
    mode = 2'b10; x0 = 11'd100; y0 = 11'd50;
    probe_px(100, 50, KEY);
    park();
    chk("idle_busy", 32'(busy), 0);
    pulse_trig();
    x0 = 11'd300; y0 = 11'd300;
    chk("trig_busy", 32'(busy), 1);
    for (int k = 0; k < 8; k++) begin
      vframe(100, 50, MARK[k / 2], 1'b0);
      chk($sformatf("play_busy_done_%0d", k), 32'({busy, done}), (k < 7) ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    chk("done_single", 32'(done), 0);
    probe_px(100, 50, KEY);
    probe_px(300, 300, KEY);
    park();

    // Retrigger at frame 2 coinciding with an advance tick
    x0 = 11'd100; y0 = 11'd50;
    pulse_trig();
    for (int k = 0; k < 5; k++) vframe(100, 50, MARK[k / 2], 1'b0);
    x0 = 11'd200; y0 = 11'd80;
    vframe(100, 50, MARK[2], 1'b1);
    chk("retrig_busy_done", 32'({busy, done}), 2);
    for (int k = 0; k < 8; k++) begin
      vframe(200, 80, MARK[k / 2], 1'b0);
      chk($sformatf("replay_busy_done_%0d", k), 32'({busy, done}), (k < 7) ? 32'd2 : 32'd1);
    end

    // Leaving ONESHOT mid-play
    pulse_trig();
    chk("leave_pre_busy", 32'(busy), 1);
    @(negedge clk); mode = 2'b01;
    @(negedge clk);
    chk("leave_busy_done", 32'({busy, done}), 0);
    mode = 2'b10;
    probe_px(200, 80, KEY);
    park();

    // Asynchronous reset during PLAY
    x0 = 11'd100; y0 = 11'd50;
    pulse_trig();
    x = 11'd100; y = 11'd50;
    repeat (3) @(negedge clk);
    chk("pre_reset_rgb", 32'(sprite_rgb), 32'h0f00);
    chk("pre_reset_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_rgb", 32'(sprite_rgb), 32'(KEY));
    chk("async_reset_busy", 32'(busy), 0);
    @(negedge clk); reset = 1'b0; x = 11'd500; y = 11'd500;
    seen_done = done;
    for (int k = 0; k < 8; k++) begin
      vframe(100, 50, KEY, 1'b0);
      seen_done = seen_done | done;
    end
    chk("no_done_after_reset", 32'(seen_done), 0);

    // OFF: key everywhere
    park();
    mode = 2'b11; x0 = 11'd0; y0 = 11'd0;
    probe_px(0, 0, KEY);
    probe_px(15, 0, KEY);
    probe_px(5, 3, KEY);
    park();

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
